// File: rtl/alloc_recirc_param_if.sv
// Request/grant bundle between the transceivers/recirculation FIFOs and alloc_recirc_param.
// Flattened per-input fields: input i occupies [i*PW +: PW] (ports) and [i*CW +: CW] (counts).
interface alloc_recirc_param_if #(
    parameter int PORTS     = 4,
    parameter int BUF_DEPTH = 4
);
    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [PORTS-1:0]       req_valid;
    logic [PORTS*PW-1:0]    req_port;
    logic [PORTS-1:0]       rbuf_valid;
    logic [PORTS*PW-1:0]    rbuf_port;
    logic [PORTS-1:0]       grant_valid;
    logic [PORTS-1:0]       grant_buf_valid;
    logic [PORTS*PW-1:0]    grant_port;
    logic [PORTS-1:0]       recirc;
    logic [PORTS-1:0]       drop;
    logic [PORTS*PORTS-1:0] switch_cfg;
    logic [PORTS-1:0]       buf_wr_cfg;
    logic [PORTS*CW-1:0]    buf_count;

    modport master (
        output req_valid, req_port, rbuf_valid, rbuf_port,
        input  grant_valid, grant_buf_valid, grant_port, recirc, drop,
               switch_cfg, buf_wr_cfg, buf_count
    );

    modport slave (
        input  req_valid, req_port, rbuf_valid, rbuf_port,
        output grant_valid, grant_buf_valid, grant_port, recirc, drop,
               switch_cfg, buf_wr_cfg, buf_count
    );
endinterface

// File: rtl/alloc_recirc_param.sv
// Slotted per-output round-robin allocator between transceiver and recirculation-buffer sources.
// Define BUF_PRIORITY_EN to let buffer heads win over transceivers at each output.
module alloc_recirc_param #(
    parameter int PORTS     = 4,
    parameter int SLOT_SIZE = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alloc_recirc_param_if.slave  bus
);
    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(SLOT_SIZE);
    localparam logic [SW-1:0] SLOT_LD = SW'(SLOT_SIZE - 1);
    localparam logic [CW-1:0] DEPTH   = CW'(BUF_DEPTH);

    logic [PORTS-1:0][SW-1:0]    r_ocnt, r_icnt;
    logic [PORTS-1:0][PW-1:0]    r_ptr, r_gport;
    logic [PORTS-1:0][CW-1:0]    r_bcnt;
    logic [PORTS-1:0]            r_gnt, r_gnt_buf, r_recirc, r_drop, r_bwr;
    logic [PORTS-1:0][PORTS-1:0] r_sw;

    logic [PORTS-1:0]            w_buf_elig, w_trx_elig;
    logic [PORTS-1:0][PW-1:0]    w_tgt, w_owin, w_gport;
    logic [PORTS-1:0][PORTS-1:0] w_mbuf, w_mtrx;
    logic [PORTS-1:0][PW:0]      w_pick;
    logic [PORTS-1:0]            w_ogrant, w_gnt, w_gnt_buf, w_recirc, w_drop;

    // Returns {found, index} of the first set mask bit at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] mask,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % PORTS;
            if (mask[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    // A non-empty requesting buffer masks its transceiver; busy inputs present nothing.
    always_comb begin
        w_buf_elig = '0;
        w_trx_elig = '0;
        w_tgt      = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_buf_elig[i] = bus.rbuf_valid[i] && (r_bcnt[i] != '0) && (r_icnt[i] == '0);
            w_trx_elig[i] = bus.req_valid[i] && !(bus.rbuf_valid[i] && (r_bcnt[i] != '0))
                            && (r_icnt[i] == '0);
            w_tgt[i]      = w_buf_elig[i] ? bus.rbuf_port[i*PW +: PW] : bus.req_port[i*PW +: PW];
        end
    end

    always_comb begin
        w_mbuf   = '0;
        w_mtrx   = '0;
        w_pick   = '0;
        w_ogrant = '0;
        w_owin   = '0;
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                w_mbuf[j][i] = w_buf_elig[i] && (w_tgt[i] == PW'(j));
                w_mtrx[j][i] = w_trx_elig[i] && (w_tgt[i] == PW'(j));
            end
`ifdef BUF_PRIORITY_EN
            w_pick[j] = (w_mbuf[j] != '0) ? rr_pick(w_mbuf[j], r_ptr[j])
                                          : rr_pick(w_mtrx[j], r_ptr[j]);
`else
            w_pick[j] = rr_pick(w_mbuf[j] | w_mtrx[j], r_ptr[j]);
`endif
            w_ogrant[j] = w_pick[j][PW] && (r_ocnt[j] == '0);
            w_owin[j]   = w_pick[j][PW-1:0];
        end
    end

    // Each input targets one output, so it can win at most one arbiter per cycle.
    always_comb begin
        w_gnt     = '0;
        w_gnt_buf = '0;
        w_gport   = '0;
        w_recirc  = '0;
        w_drop    = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (w_ogrant[j]) begin
                if (w_buf_elig[w_owin[j]]) w_gnt_buf[w_owin[j]] = 1'b1;
                else                       w_gnt[w_owin[j]]     = 1'b1;
                w_gport[w_owin[j]] = PW'(j);
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            w_recirc[i] = w_trx_elig[i] && !w_gnt[i] && (r_bcnt[i] <  DEPTH);
            w_drop[i]   = w_trx_elig[i] && !w_gnt[i] && (r_bcnt[i] >= DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ocnt    <= '0;
            r_icnt    <= '0;
            r_ptr     <= '0;
            r_gport   <= '0;
            r_bcnt    <= '0;
            r_gnt     <= '0;
            r_gnt_buf <= '0;
            r_recirc  <= '0;
            r_drop    <= '0;
            r_bwr     <= '0;
            r_sw      <= '0;
        end else begin
            r_gnt     <= w_gnt;
            r_gnt_buf <= w_gnt_buf;
            r_gport   <= w_gport;
            r_recirc  <= w_recirc;
            r_drop    <= w_drop;
            // Connection bits drop one cycle after the counter reaches 0, giving a full slot.
            for (int j = 0; j < PORTS; j++) begin
                if (w_ogrant[j]) begin
                    r_ocnt[j] <= SLOT_LD;
                    r_ptr[j]  <= (w_owin[j] == PW'(PORTS - 1)) ? '0 : w_owin[j] + 1'b1;
                    r_sw[j]   <= PORTS'(1) << w_owin[j];
                end else if (r_ocnt[j] != '0) begin
                    r_ocnt[j] <= r_ocnt[j] - 1'b1;
                end else begin
                    r_sw[j]   <= '0;
                end
            end
            for (int i = 0; i < PORTS; i++) begin
                if (w_gnt[i] || w_gnt_buf[i] || w_recirc[i]) r_icnt[i] <= SLOT_LD;
                else if (r_icnt[i] != '0)                     r_icnt[i] <= r_icnt[i] - 1'b1;
                if (w_gnt_buf[i])     r_bcnt[i] <= r_bcnt[i] - 1'b1;
                else if (w_recirc[i]) r_bcnt[i] <= r_bcnt[i] + 1'b1;
                if (w_recirc[i])          r_bwr[i] <= 1'b1;
                else if (r_icnt[i] == '0) r_bwr[i] <= 1'b0;
            end
        end
    end

    assign bus.grant_valid     = r_gnt;
    assign bus.grant_buf_valid = r_gnt_buf;
    assign bus.grant_port      = r_gport;
    assign bus.recirc          = r_recirc;
    assign bus.drop            = r_drop;
    assign bus.switch_cfg      = r_sw;
    assign bus.buf_wr_cfg      = r_bwr;
    assign bus.buf_count       = r_bcnt;
endmodule

// File: tb/tb_alloc_recirc_param.sv
// Directed bench for alloc_recirc_param: one DUT with BUF_DEPTH=4, one with BUF_DEPTH=1.
// Expected values depend on BUF_PRIORITY_EN in the priority step.
module tb_alloc_recirc_param;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alloc_recirc_param_if #(.PORTS(4), .BUF_DEPTH(4)) if0 ();
    alloc_recirc_param_if #(.PORTS(4), .BUF_DEPTH(1)) if1 ();

    alloc_recirc_param #(.PORTS(4), .SLOT_SIZE(8), .BUF_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    alloc_recirc_param #(.PORTS(4), .SLOT_SIZE(8), .BUF_DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        if0.req_valid = '0; if0.req_port = '0; if0.rbuf_valid = '0; if0.rbuf_port = '0;
        if1.req_valid = '0; if1.req_port = '0; if1.rbuf_valid = '0; if1.rbuf_port = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",  32'(if0.grant_valid), 32'h0);
        chk("rst_cfg",    32'(if0.switch_cfg),  32'h0);
        chk("rst_bcnt",   32'(if0.buf_count),   32'h0);
        chk("rst_d1_bwr", 32'(if1.buf_wr_cfg),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single requester: input 0 -> output 2, then blocked and re-granted
        if0.req_valid = 4'b0001; if0.req_port = 8'h02;
        tick();                                                  // E0
        chk("t1_gnt",  32'(if0.grant_valid), 32'h1);
        chk("t1_port", 32'(if0.grant_port),  32'h02);
        chk("t1_cfg",  32'(if0.switch_cfg),  32'h0100);
        if0.req_valid = 4'b0000;
        repeat (3) tick();                                       // E1..E3
        chk("t1_cfg_e3", 32'(if0.switch_cfg), 32'h0100);
        if0.req_valid = 4'b0001;
        tick();                                                  // E4
        chk("t1_blk_gnt", 32'(if0.grant_valid), 32'h0);
        chk("t1_blk_rec", 32'(if0.recirc),      32'h0);
        repeat (3) tick();                                       // E5..E7
        chk("t1_cfg_e7", 32'(if0.switch_cfg),  32'h0100);
        chk("t1_gnt_e7", 32'(if0.grant_valid), 32'h0);
        tick();                                                  // E8
        chk("t1_regnt",  32'(if0.grant_valid), 32'h1);
        chk("t1_cfg_e8", 32'(if0.switch_cfg),  32'h0100);
        if0.req_valid = 4'b0000;
        repeat (7) tick();                                       // E9..E15
        chk("t1_cfg_e15", 32'(if0.switch_cfg), 32'h0100);
        tick();                                                  // E16
        chk("t1_cfg_e16", 32'(if0.switch_cfg), 32'h0);

        // Inputs 0,1,3 contend for output 1 over three slots
        if0.req_valid = 4'b1011; if0.req_port = 8'h45;
        tick();                                                  // F0
        chk("t2_gnt0",  32'(if0.grant_valid), 32'h1);
        chk("t2_port0", 32'(if0.grant_port),  32'h01);
        chk("t2_rec0",  32'(if0.recirc),      32'ha);
        chk("t2_bcnt0", 32'(if0.buf_count),   32'h208);
        chk("t2_bwr0",  32'(if0.buf_wr_cfg),  32'ha);
        if0.req_valid = 4'b1010;
        repeat (7) tick();                                       // F1..F7
        chk("t2_bwr7", 32'(if0.buf_wr_cfg),  32'ha);
        chk("t2_gnt7", 32'(if0.grant_valid), 32'h0);
        tick();                                                  // F8
        chk("t2_gnt1",  32'(if0.grant_valid), 32'h2);
        chk("t2_port1", 32'(if0.grant_port),  32'h04);
        chk("t2_rec1",  32'(if0.recirc),      32'h8);
        chk("t2_bcnt1", 32'(if0.buf_count),   32'h408);
        chk("t2_bwr1",  32'(if0.buf_wr_cfg),  32'h8);
        if0.req_valid = 4'b1000;
        repeat (8) tick();                                       // F9..F16
        chk("t2_gnt3",  32'(if0.grant_valid), 32'h8);
        chk("t2_port3", 32'(if0.grant_port),  32'h40);
        chk("t2_cfg3",  32'(if0.switch_cfg),  32'h0080);
        chk("t2_rec3",  32'(if0.recirc),      32'h0);
        idle_in();
        repeat (8) tick();                                       // F17..F24
        chk("t2_cfg_end",  32'(if0.switch_cfg), 32'h0);
        chk("t2_bcnt_end", 32'(if0.buf_count),  32'h408);

        // Input 0 transceiver vs input 3 buffer head, both to output 0, ptr[0]=0
        if0.req_valid = 4'b0001; if0.req_port = 8'h00;
        if0.rbuf_valid = 4'b1000; if0.rbuf_port = 8'h00;
        tick();
        idle_in();
`ifdef BUF_PRIORITY_EN
        chk("pri_gnt",  32'(if0.grant_valid),     32'h0);
        chk("pri_gbuf", 32'(if0.grant_buf_valid), 32'h8);
        chk("pri_cfg",  32'(if0.switch_cfg),      32'h0008);
        chk("pri_bcnt", 32'(if0.buf_count),       32'h209);
        chk("pri_rec",  32'(if0.recirc),          32'h1);
`else
        chk("pri_gnt",  32'(if0.grant_valid),     32'h1);
        chk("pri_gbuf", 32'(if0.grant_buf_valid), 32'h0);
        chk("pri_cfg",  32'(if0.switch_cfg),      32'h0001);
        chk("pri_bcnt", 32'(if0.buf_count),       32'h408);
        chk("pri_rec",  32'(if0.recirc),          32'h0);
`endif

        // Asynchronous reset in cycle 3 of the slot
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        chk("ar_cfg",  32'(if0.switch_cfg),      32'h0);
        chk("ar_bcnt", 32'(if0.buf_count),       32'h0);
        chk("ar_gnt",  32'(if0.grant_valid),     32'h0);
        chk("ar_gbuf", 32'(if0.grant_buf_valid), 32'h0);
        chk("ar_port", 32'(if0.grant_port),      32'h0);
        chk("ar_bwr",  32'(if0.buf_wr_cfg),      32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Empty buffer with rbuf_valid: transceiver competes and wins on first edge
        if0.req_valid = 4'b0010;  if0.req_port = 8'h08;
        if0.rbuf_valid = 4'b0010; if0.rbuf_port = 8'h0C;
        tick();
        chk("eb_gnt",  32'(if0.grant_valid),     32'h2);
        chk("eb_gbuf", 32'(if0.grant_buf_valid), 32'h0);
        chk("eb_port", 32'(if0.grant_port),      32'h08);
        chk("eb_cfg",  32'(if0.switch_cfg),      32'h0200);
        idle_in();

        // BUF_DEPTH=1: fill buffer 2, then a second loss drops
        if1.req_valid = 4'b0101; if1.req_port = 8'h33;
        tick();                                                  // G0
        chk("dr_gnt0",  32'(if1.grant_valid), 32'h1);
        chk("dr_rec0",  32'(if1.recirc),      32'h4);
        chk("dr_bcnt0", 32'(if1.buf_count),   32'h4);
        chk("dr_bwr0",  32'(if1.buf_wr_cfg),  32'h4);
        if1.req_valid = 4'b0100;
        repeat (7) tick();                                       // G1..G7
        if1.req_valid = 4'b0110; if1.req_port = 8'h3F;
        tick();                                                  // G8
        chk("dr_gnt1",  32'(if1.grant_valid), 32'h2);
        chk("dr_drop",  32'(if1.drop),        32'h4);
        chk("dr_rec1",  32'(if1.recirc),      32'h0);
        chk("dr_bcnt1", 32'(if1.buf_count),   32'h4);
        chk("dr_bwr1",  32'(if1.buf_wr_cfg),  32'h0);
        idle_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
